// File: rtl/ddr_preload_pkg.sv
// Shared types and constants for the DDR preload engine.
package ddr_preload_pkg;

  localparam int unsigned BURSTCOUNT_W = 7;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL    = 3'd1,
    WRITE   = 3'd2,
    RD_REQ  = 3'd3,
    RD_WAIT = 3'd4,
    DONE    = 3'd5,
    FAIL    = 3'd6
  } state_t;

  function automatic int unsigned words_per_beat(input int unsigned data_w,
                                                 input int unsigned word_w);
    return data_w / word_w;
  endfunction

endpackage

// File: rtl/ddr_word_packer.sv
// Packs a stream of WORD_W words, LSB first, into DATA_W beats.
module ddr_word_packer
  import ddr_preload_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned DATA_W = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word,
  output logic              beat_valid,
  output logic [DATA_W-1:0] beat
);

  localparam int unsigned WPB   = words_per_beat(DATA_W, WORD_W);
  localparam int unsigned CNT_W = (WPB > 1) ? $clog2(WPB) : 1;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] acc;
  logic              last;

  assign last = (cnt == CNT_W'(WPB - 1));

  // The beat is presented in the same cycle as its final word.
  always_comb begin
    beat = acc;
    beat[cnt*WORD_W +: WORD_W] = word;
  end

  assign beat_valid = word_valid & last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (word_valid) begin
      acc <= beat;
      cnt <= last ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ddr_preload_engine.sv
// Preloads a block of DDR over Avalon-MM from a word stream, with optional read-back verify.
module ddr_preload_engine
  import ddr_preload_pkg::*;
#(
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned ADDR_W    = 25,
  parameter int unsigned NUM_BEATS = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned VERIFY    = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [WORD_W-1:0]       src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic                    busy,
  output logic                    setup_done,
  output logic                    setup_fail,
  output logic [15:0]             err_beat,
  output logic [ADDR_W-1:0]       amm_addr,
  output logic [DATA_W-1:0]       amm_writedata,
  output logic [DATA_W/8-1:0]     amm_byteenable,
  output logic [BURSTCOUNT_W-1:0] amm_burstcount,
  output logic                    amm_write,
  output logic                    amm_read,
  input  logic                    amm_ready,
  input  logic                    amm_readdatavalid,
  input  logic [DATA_W-1:0]       amm_readdata
);

  localparam int unsigned DONE_W    = $clog2(NUM_BEATS + 1);
  localparam int unsigned IDX_W     = BURSTCOUNT_W;
  localparam int unsigned BUF_IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  state_t              state;
  logic [ADDR_W-1:0]   burst_addr;
  logic [DONE_W-1:0]   beats_done;
  logic [IDX_W-1:0]    burst_len;
  logic [IDX_W-1:0]    beat_idx;
  logic                mismatch_seen;
  logic [15:0]         err_q;
  logic [DATA_W-1:0]   burst_buf [BURST_LEN];

  logic                start_accept;
  logic                word_fire;
  logic                beat_valid;
  logic [DATA_W-1:0]   packed_beat;
  logic [BUF_IDX_W-1:0] buf_idx;
  logic                last_beat;
  logic [DONE_W-1:0]   done_after;
  logic                all_written;
  logic                rd_mismatch;
  logic                burst_ok;

  function automatic logic [IDX_W-1:0] next_len(input logic [DONE_W-1:0] done);
    int unsigned remaining;
    remaining = NUM_BEATS - 32'(done);
    return (remaining < BURST_LEN) ? IDX_W'(remaining) : IDX_W'(BURST_LEN);
  endfunction

  assign start_accept = start && (state == IDLE || state == DONE || state == FAIL);
  assign src_ready    = (state == FILL);
  assign word_fire    = src_valid & src_ready;

  ddr_word_packer #(
    .WORD_W (WORD_W),
    .DATA_W (DATA_W)
  ) u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_accept),
    .word_valid (word_fire),
    .word       (src_data),
    .beat_valid (beat_valid),
    .beat       (packed_beat)
  );

  assign buf_idx     = beat_idx[BUF_IDX_W-1:0];
  assign last_beat   = (beat_idx == burst_len - IDX_W'(1));
  assign done_after  = beats_done + DONE_W'(burst_len);
  assign all_written = (done_after == DONE_W'(NUM_BEATS));
  assign rd_mismatch = (amm_readdata != burst_buf[buf_idx]);

  // A burst is retired either on its last accepted write (no verify) or on a
  // clean read-back of its last beat.
  assign burst_ok = ((state == WRITE) && amm_ready && last_beat && (VERIFY == 0)) ||
                    ((state == RD_WAIT) && amm_readdatavalid && last_beat &&
                     !mismatch_seen && !rd_mismatch);

  assign busy           = (state == FILL) || (state == WRITE) ||
                          (state == RD_REQ) || (state == RD_WAIT);
  assign setup_done     = (state == DONE);
  assign setup_fail     = (state == FAIL);
  assign err_beat       = err_q;
  assign amm_write      = (state == WRITE);
  assign amm_read       = (state == RD_REQ);
  assign amm_addr       = burst_addr;
  assign amm_writedata  = amm_write ? burst_buf[buf_idx] : '0;
  assign amm_byteenable = amm_write ? '1 : '0;
  assign amm_burstcount = (amm_write || amm_read) ? burst_len : '0;

  always_ff @(posedge clk) begin
    if (state == FILL && beat_valid) begin
      burst_buf[buf_idx] <= packed_beat;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      burst_addr    <= '0;
      beats_done    <= '0;
      burst_len     <= '0;
      beat_idx      <= '0;
      mismatch_seen <= 1'b0;
      err_q         <= '0;
    end else begin
      case (state)
        IDLE, DONE, FAIL: begin
          if (start) begin
            state         <= FILL;
            burst_addr    <= base_addr;
            beats_done    <= '0;
            burst_len     <= next_len('0);
            beat_idx      <= '0;
            mismatch_seen <= 1'b0;
            err_q         <= '0;
          end
        end
        FILL: begin
          if (beat_valid) begin
            if (last_beat) begin
              beat_idx <= '0;
              state    <= WRITE;
            end else begin
              beat_idx <= beat_idx + IDX_W'(1);
            end
          end
        end
        WRITE: begin
          if (amm_ready) begin
            if (last_beat) begin
              beat_idx <= '0;
              if (VERIFY != 0) state <= RD_REQ;
            end else begin
              beat_idx <= beat_idx + IDX_W'(1);
            end
          end
        end
        RD_REQ: begin
          if (amm_ready) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (amm_readdatavalid) begin
            if (rd_mismatch && !mismatch_seen) begin
              mismatch_seen <= 1'b1;
              err_q         <= 16'(beats_done) + 16'(beat_idx);
            end
            if (last_beat) begin
              beat_idx <= '0;
              if (mismatch_seen || rd_mismatch) state <= FAIL;
            end else begin
              beat_idx <= beat_idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (burst_ok) begin
        beats_done <= done_after;
        burst_addr <= burst_addr + ADDR_W'(burst_len);
        burst_len  <= next_len(done_after);
        state      <= all_written ? DONE : FILL;
      end
    end
  end

endmodule

// File: tb/tb_ddr_preload_engine.sv
// Self-checking bench: scenario table run against a memory model and a burst-plan reference.
module tb_ddr_preload_engine;

  localparam int unsigned DW = 256;
  localparam int unsigned WW = 32;
  localparam int unsigned AW = 25;
  localparam int AMASK = 32'h01FF_FFFF;

  typedef struct {
    int addr;
    int len;
  } burst_t;

  typedef struct {
    bit          sel;
    logic [24:0] base;
    int          ready_pct;
    int          gap_pct;
    int          corrupt;
    bit          exp_fail;
    logic [15:0] exp_err;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [AW-1:0] base_addr;
  logic [WW-1:0] src_data;
  logic          src_valid;
  logic          amm_ready;
  logic          amm_readdatavalid;
  logic [DW-1:0] amm_readdata;

  logic a_src_ready, a_busy, a_done, a_fail, a_write, a_read;
  logic [15:0] a_err;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [31:0] a_be;
  logic [6:0] a_bc;
  logic b_src_ready, b_busy, b_done, b_fail, b_write, b_read;
  logic [15:0] b_err;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic [31:0] b_be;
  logic [6:0] b_bc;

  always #5 clk = ~clk;

  ddr_preload_engine #(
    .DATA_W(256), .WORD_W(32), .ADDR_W(25), .NUM_BEATS(4), .BURST_LEN(8), .VERIFY(0)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base_addr),
    .src_data(src_data), .src_valid(src_valid), .src_ready(a_src_ready),
    .busy(a_busy), .setup_done(a_done), .setup_fail(a_fail), .err_beat(a_err),
    .amm_addr(a_addr), .amm_writedata(a_wdata), .amm_byteenable(a_be),
    .amm_burstcount(a_bc), .amm_write(a_write), .amm_read(a_read),
    .amm_ready(amm_ready), .amm_readdatavalid(amm_readdatavalid), .amm_readdata(amm_readdata)
  );

  ddr_preload_engine #(
    .DATA_W(256), .WORD_W(32), .ADDR_W(25), .NUM_BEATS(10), .BURST_LEN(4), .VERIFY(1)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_addr),
    .src_data(src_data), .src_valid(src_valid), .src_ready(b_src_ready),
    .busy(b_busy), .setup_done(b_done), .setup_fail(b_fail), .err_beat(b_err),
    .amm_addr(b_addr), .amm_writedata(b_wdata), .amm_byteenable(b_be),
    .amm_burstcount(b_bc), .amm_write(b_write), .amm_read(b_read),
    .amm_ready(amm_ready), .amm_readdatavalid(amm_readdatavalid), .amm_readdata(amm_readdata)
  );

  logic [341:0] a_outs, b_outs;
  assign a_outs = {a_busy, a_done, a_fail, a_err, a_addr, a_wdata, a_be, a_bc, a_write, a_read, a_src_ready};
  assign b_outs = {b_busy, b_done, b_fail, b_err, b_addr, b_wdata, b_be, b_bc, b_write, b_read, b_src_ready};

  bit sel;
  logic          cur_src_ready, cur_busy, cur_done, cur_fail, cur_write, cur_read;
  logic [15:0]   cur_err;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] cur_wdata;
  logic [31:0]   cur_be;
  logic [6:0]    cur_bc;
  assign cur_src_ready = sel ? b_src_ready : a_src_ready;
  assign cur_busy      = sel ? b_busy  : a_busy;
  assign cur_done      = sel ? b_done  : a_done;
  assign cur_fail      = sel ? b_fail  : a_fail;
  assign cur_write     = sel ? b_write : a_write;
  assign cur_read      = sel ? b_read  : a_read;
  assign cur_err       = sel ? b_err   : a_err;
  assign cur_addr      = sel ? b_addr  : a_addr;
  assign cur_wdata     = sel ? b_wdata : a_wdata;
  assign cur_be        = sel ? b_be    : a_be;
  assign cur_bc        = sel ? b_bc    : a_bc;

  int checks = 0;
  int errors = 0;

  // Memory/stream model state shared between the bus model and the test sequence.
  logic [DW-1:0] mem [int];
  burst_t        wlog[$];
  int            rq[$];
  int            rlog_n, wr_cnt, wr_base, wr_len, proto_err, total_wr;
  int            ready_pct, gap_pct;
  bit            feeding, corrupt_en;
  int            corrupt_addr;
  logic [WW-1:0] words [80];
  int            widx, nwords;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Avalon slave + source driver; acts on the falling edge so the DUT sees stable inputs.
  initial begin
    logic [DW-1:0] d;
    int a;
    amm_ready = 1'b0; amm_readdatavalid = 1'b0; amm_readdata = '0;
    src_valid = 1'b0; src_data = '0;
    forever begin
      @(negedge clk);
      amm_readdatavalid = 1'b0;
      if (rq.size() > 0 && $urandom_range(99) < 70) begin
        a = rq.pop_front();
        d = mem.exists(a) ? mem[a] : '0;
        if (corrupt_en && a == corrupt_addr) d[200] = ~d[200];
        amm_readdatavalid = 1'b1;
        amm_readdata = d;
      end else if (cur_src_ready && $urandom_range(99) < 20) begin
        amm_readdatavalid = 1'b1;
        for (int k = 0; k < 8; k++) amm_readdata[k*32 +: 32] = $urandom;
      end
      amm_ready = (int'($urandom_range(99)) < ready_pct);
      if (cur_write && cur_be !== '1) proto_err++;
      if (cur_write && cur_read) proto_err++;
      if (cur_write && wr_cnt > 0 && (int'(cur_addr) != wr_base || int'(cur_bc) != wr_len)) proto_err++;
      if (cur_write && amm_ready) begin
        if (wr_cnt == 0) begin
          wr_base = int'(cur_addr);
          wr_len  = int'(cur_bc);
          wlog.push_back('{wr_base, wr_len});
        end
        mem[(wr_base + wr_cnt) & AMASK] = cur_wdata;
        wr_cnt++;
        total_wr++;
        if (wr_cnt >= wr_len) wr_cnt = 0;
      end
      if (cur_read && amm_ready) begin
        for (int i = 0; i < int'(cur_bc); i++) rq.push_back((int'(cur_addr) + i) & AMASK);
        rlog_n++;
      end
      src_valid = 1'b0;
      if (feeding && widx < nwords && int'($urandom_range(99)) >= gap_pct) begin
        src_valid = 1'b1;
        src_data  = words[widx];
        if (cur_src_ready) widx++;
      end
    end
  end

  task automatic pulse_start();
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #2;
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic prepare(input vec_t v, input bit counting_words);
    int nb;
    nb = v.sel ? 10 : 4;
    mem.delete(); wlog.delete(); rq.delete();
    rlog_n = 0; wr_cnt = 0; proto_err = 0; total_wr = 0; widx = 0;
    sel = v.sel;
    nwords = nb * 8;
    for (int i = 0; i < nwords; i++) words[i] = counting_words ? WW'(i) : WW'($urandom);
    ready_pct = v.ready_pct;
    gap_pct = v.gap_pct;
    corrupt_en = (v.corrupt >= 0);
    corrupt_addr = (int'(v.base) + v.corrupt) & AMASK;
    base_addr = v.base;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int nb, bl, off, len, cyc, written;
    burst_t exp_b[$];
    logic [DW-1:0] eb, got;
    string tag;
    tag = $sformatf("v%0d", idx);
    nb = v.sel ? 10 : 4;
    bl = v.sel ? 4 : 8;
    prepare(v, idx == 0);
    feeding = 1'b1;
    pulse_start();
    repeat (5) @(posedge clk);
    #2;
    base_addr = v.base ^ 25'h155;
    pulse_start();
    cyc = 0;
    while (!(cur_done || cur_fail) && cyc < 5000) begin
      @(posedge clk); #2;
      cyc++;
    end
    feeding = 1'b0;
    check({tag, "_finished"}, cur_done | cur_fail, 1'b1);
    check({tag, "_setup_done"}, cur_done, !v.exp_fail);
    check({tag, "_setup_fail"}, cur_fail, v.exp_fail);
    if (v.exp_fail) check({tag, "_err_beat"}, cur_err, v.exp_err);
    check({tag, "_busy_srcready"}, {cur_busy, cur_src_ready}, 2'b00);
    check({tag, "_protocol"}, proto_err, 0);

    off = 0;
    while (off < nb) begin
      len = (nb - off < bl) ? nb - off : bl;
      exp_b.push_back('{(int'(v.base) + off) & AMASK, len});
      off += len;
      if (v.exp_fail && v.corrupt >= off - len && v.corrupt < off) break;
    end
    written = off;
    check({tag, "_nbursts"}, wlog.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < wlog.size(); k++) begin
      check($sformatf("%s_burst%0d_addr", tag, k), wlog[k].addr, exp_b[k].addr);
      check($sformatf("%s_burst%0d_len", tag, k), wlog[k].len, exp_b[k].len);
    end
    if (v.sel) check({tag, "_nreads"}, rlog_n, exp_b.size());
    check({tag, "_total_beats"}, total_wr, written);
    for (int j = 0; j < written; j++) begin
      for (int w = 0; w < 8; w++) eb[w*32 +: 32] = words[j*8 + w];
      got = mem.exists((int'(v.base) + j) & AMASK) ? mem[(int'(v.base) + j) & AMASK] : 'x;
      check($sformatf("%s_mem_beat%0d", tag, j), got, eb);
    end
  endtask

  vec_t vecs[8];
  vec_t post_reset;

  initial begin
    int cyc;
    vecs[0] = '{1'b0, 25'h0000100, 100, 0,  -1, 1'b0, 16'd0};
    vecs[1] = '{1'b0, 25'h1FFFFFE, 100, 0,  -1, 1'b0, 16'd0};
    vecs[2] = '{1'b1, 25'h0000040, 100, 0,  -1, 1'b0, 16'd0};
    vecs[3] = '{1'b0, 25'h0003000, 50,  40, -1, 1'b0, 16'd0};
    vecs[4] = '{1'b1, 25'h1FFFFFD, 50,  40, -1, 1'b0, 16'd0};
    vecs[5] = '{1'b1, 25'h0000800, 100, 0,   5, 1'b1, 16'd5};
    vecs[6] = '{1'b1, 25'h0001234, 60,  30,  9, 1'b1, 16'd9};
    vecs[7] = '{1'b1, 25'h0000010, 70,  20,  0, 1'b1, 16'd0};
    post_reset = '{1'b0, 25'h0000055, 80, 10, -1, 1'b0, 16'd0};

    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; base_addr = '0;
    sel = 1'b0; ready_pct = 100; gap_pct = 0; feeding = 1'b0; corrupt_en = 1'b0;
    rlog_n = 0; wr_cnt = 0; proto_err = 0; total_wr = 0; widx = 0; nwords = 0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs_a", a_outs, '0);
    check("reset_outputs_b", b_outs, '0);
    reset = 1'b0;
    @(posedge clk); #2;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Reset while a write burst is stalled on amm_ready.
    prepare('{1'b0, 25'h0000777, 0, 0, -1, 1'b0, 16'd0}, 1'b0);
    feeding = 1'b1;
    pulse_start();
    cyc = 0;
    while (!a_write && cyc < 500) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("midwrite_reached_write", a_write, 1'b1);
    reset = 1'b1;
    #1;
    check("midwrite_reset_outputs", a_outs, '0);
    feeding = 1'b0;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    run_vec(post_reset, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_preload_engine.md
DDR_PRELOAD_ENGINE -- requirements
Module: ddr_preload_engine

Interface
REQ-001 SHALL have parameters DATA_W (default 256; Avalon beat width, multiple of WORD_W) and WORD_W (default 32; source word width).
REQ-002 SHALL have parameters ADDR_W (default 25; beat address), NUM_BEATS (default 4, >=1; beats per setup) and BURST_LEN (default 8, 1..64; max beats per burst).
REQ-003 SHALL have parameter VERIFY (default 0); 1 enables read-back compare after each burst.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset  in  1  one clock; reset is asynchronous and active-high.
REQ-006 start  in  1  pulse; begins setup when idle.
REQ-007 base_addr  in  ADDR_W  first beat address, sampled on accepted start.
REQ-008 src_data / src_valid / src_ready  in / in / out  WORD_W / 1 / 1  word stream; transfer when valid & ready.
REQ-009 busy / setup_done / setup_fail  out  1 each  engine active / completed OK / verify mismatch.
REQ-010 err_beat  out  16  index of first mismatching beat from 0; valid while setup_fail.
REQ-011 amm_addr, amm_writedata, amm_byteenable, amm_burstcount  out  ADDR_W, DATA_W, DATA_W/8, 7  Avalon-MM request fields.
REQ-012 amm_write, amm_read  out  1 each  Avalon-MM commands.
REQ-013 amm_ready, amm_readdatavalid, amm_readdata  in  1, 1, DATA_W  Avalon-MM response; amm_ready=1 accepts the current command/beat.

Function
REQ-014 States SHALL be IDLE, FILL, WRITE, RD_REQ, RD_WAIT, DONE, FAIL.
REQ-015 IDLE/DONE/FAIL + start -> FILL: latch base_addr, clear beat counter, setup_done and setup_fail; start in any other state SHALL be ignored.
REQ-016 FILL: src_ready=1; words packed LSB first, DATA_W/WORD_W words per beat, into a burst buffer of BURST_LEN beats; when this burst's beats are full -> WRITE the next cycle.
REQ-017 Burst length SHALL be min(BURST_LEN, NUM_BEATS - beats_done); the last burst is shorter when NUM_BEATS is not a multiple of BURST_LEN.
REQ-018 WRITE: amm_write=1, amm_addr = burst start address and amm_burstcount = burst length, both held for the whole burst; amm_writedata advances only on a cycle with amm_ready=1; amm_byteenable all ones.
REQ-019 After the last beat is accepted: VERIFY=1 -> RD_REQ; else the next burst -> FILL, or DONE if all beats are written.
REQ-020 RD_REQ: amm_read=1 with the same addr/burstcount until amm_ready=1 (one cycle), then -> RD_WAIT.
REQ-021 RD_WAIT: each amm_readdatavalid beat SHALL be compared with the buffered beat; on the first mismatch, latch err_beat and go to FAIL after the burst drains; all equal -> next burst or DONE.
REQ-022 amm_readdatavalid outside RD_WAIT SHALL be ignored.
REQ-023 Addresses SHALL increment by 1 per beat and wrap modulo 2^ADDR_W.
REQ-024 DONE: setup_done=1, busy=0. FAIL: setup_fail=1, busy=0. Both hold until the next start.
REQ-025 busy=1 in FILL through RD_WAIT. src_ready=0 outside FILL.
REQ-026 Idle cycles on src_valid, or amm_ready held low, SHALL stall without losing or duplicating data.

Reset
REQ-027 On reset, the state SHALL be IDLE immediately, including mid-burst.
REQ-028 On reset, every output SHALL be 0 (amm_addr, amm_writedata and err_beat included), and the buffer contents are don't-care.

Structure
REQ-029 ddr_preload_pkg SHALL hold the state enum, the burstcount width (7) and the helper constant WORDS_PER_BEAT function.
REQ-030 The word-to-beat packer SHALL be the sub-module ddr_word_packer (WORD_W, DATA_W).

Verification
REQ-031 Defaults, VERIFY=0, 32 words 0..31, amm_ready=1 -> one burst of 4 at base_addr, beat0 = {words 7..0}, setup_done after the last beat.
REQ-032 NUM_BEATS=10, BURST_LEN=4 -> bursts of 4, 4, 2 at base, base+4, base+8.
REQ-033 amm_ready toggling randomly with src_valid gaps -> memory model contents equal the packed stream.
REQ-034 VERIFY=1, model corrupts beat 5 -> setup_fail=1, err_beat=5, setup_done=0.
REQ-035 base_addr=2^25-2, NUM_BEATS=4 -> addresses 0x1FFFFFE, 0x1FFFFFF, 0x0, 0x1.
REQ-036 Reset asserted mid-WRITE -> all outputs 0 at once; a fresh start completes normally.
